// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared FSM encoding, funct3 constants and access-size helpers
package load_store_unit_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    WRITE = ST_WRITE,
    DONE  = ST_DONE,
    ERR   = ST_ERR
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Any code with bit 1 set (010, 011, 110, 111) is a full-word access.
  function automatic logic op_is_byte(input logic [2:0] op);
    return op[1:0] == 2'b00;
  endfunction

  function automatic logic op_is_half(input logic [2:0] op);
    return op[1:0] == 2'b01;
  endfunction

  function automatic logic op_is_word(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lo);
    return (op_is_half(op) && lo[0]) || (op_is_word(op) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request and data-memory signals; misaligned exists only with MISALIGN_TRAP_EN
interface load_store_unit_if #(parameter int N = 32);

  logic         req;
  logic         isStore;
  logic [2:0]   memOp;
  logic [N-1:0] addr;
  logic [N-1:0] storeData;
  logic         busy;
  logic         done;
  logic [N-1:0] loadData;
  logic [N-1:0] memAdr;
  logic [N-1:0] writeData;
  logic         memWrite;
  logic [N-1:0] readData;
`ifdef MISALIGN_TRAP_EN
  logic         misaligned;

  modport master (
    output req, isStore, memOp, addr, storeData, readData,
    input  busy, done, loadData, memAdr, writeData, memWrite, misaligned
  );
  modport slave (
    input  req, isStore, memOp, addr, storeData, readData,
    output busy, done, loadData, memAdr, writeData, memWrite, misaligned
  );
`else
  modport master (
    output req, isStore, memOp, addr, storeData, readData,
    input  busy, done, loadData, memAdr, writeData, memWrite
  );
  modport slave (
    input  req, isStore, memOp, addr, storeData, readData,
    output busy, done, loadData, memAdr, writeData, memWrite
  );
`endif

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational byte/halfword lane extract+extend for loads and merge for stores
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] load_word_i,
  input  logic [31:0] store_base_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  always_comb begin
    byte_v       = load_word_i[{lane_i, 3'b000} +: 8];
    half_v       = lane_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    sext         = ~op_i[2];
    load_data_o  = load_word_i;
    store_word_o = store_data_i;
    if (op_is_byte(op_i)) begin
      load_data_o  = {{24{sext & byte_v[7]}}, byte_v};
      store_word_o = store_base_i;
      store_word_o[{lane_i, 3'b000} +: 8] = store_data_i[7:0];
    end else if (op_is_half(op_i)) begin
      load_data_o  = {{16{sext & half_v[15]}}, half_v};
      store_word_o = lane_i[1] ? {store_data_i[15:0], store_base_i[15:0]}
                               : {store_base_i[31:16], store_data_i[15:0]};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store FSM with read-modify-write for sub-word stores; MISALIGN_TRAP_EN adds the ERR trap
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic clk,
  input  logic rst,
  load_store_unit_if.slave bus
);

  lsu_state_e   state_q, state_d;
  logic         is_store_q, is_store_d;
  logic [2:0]   op_q, op_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] sdata_q, sdata_d;
  logic [N-1:0] buf_q, buf_d;
  logic [N-1:0] load_data_q, load_data_d;

  logic         mem_write;
  logic         done;
  logic         misal;
  logic [N-1:0] wdata;
  logic [N-1:0] load_ext;
  logic [N-1:0] merged;
  logic         trap;

  lsu_lane_align u_lane (
    .op_i         (op_q),
    .lane_i       (addr_q[1:0]),
    .load_word_i  (bus.readData),
    .store_base_i (buf_q),
    .store_data_i (sdata_q),
    .load_data_o  (load_ext),
    .store_word_o (merged)
  );

`ifdef MISALIGN_TRAP_EN
  assign trap = op_misaligned(bus.memOp, bus.addr[1:0]);
  assign bus.misaligned = misal;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      op_q        <= 3'b000;
      addr_q      <= '0;
      sdata_q     <= '0;
      buf_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      buf_q       <= buf_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    op_d        = op_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    buf_d       = buf_q;
    load_data_d = load_data_q;
    mem_write   = 1'b0;
    done        = 1'b0;
    misal       = 1'b0;
    wdata       = '0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          is_store_d = bus.isStore;
          op_d       = bus.memOp;
          addr_d     = bus.addr;
          sdata_d    = bus.storeData;
          if (trap)
            state_d = ERR;
          else if (bus.isStore && op_is_word(bus.memOp))
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        buf_d = bus.readData;
        if (is_store_q) begin
          state_d = WRITE;
        end else begin
          load_data_d = load_ext;
          state_d     = DONE;
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        wdata     = merged;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        misal   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done;
  assign bus.loadData  = load_data_q;
  assign bus.memAdr    = {addr_q[N-1:2], 2'b00};
  assign bus.writeData = wdata;
  assign bus.memWrite  = mem_write;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a word memory model
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  load_store_unit_if #(.N(32)) bus ();

  load_store_unit #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign bus.readData = mem[bus.memAdr[11:2]];
  always @(posedge clk) if (bus.memWrite) mem[bus.memAdr[11:2]] <= bus.writeData;

  int          lat, wr_cnt, wr_cyc;
  logic [31:0] wr_data, wr_adr, ld;
  logic        mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic run_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    @(negedge clk);
    bus.req = 1'b1; bus.isStore = st; bus.memOp = op; bus.addr = a; bus.storeData = d;
    @(posedge clk);
    #1;
    if (hold) begin
      bus.isStore = 1'b1; bus.memOp = SW; bus.storeData = 32'h0;
    end else begin
      bus.req = 1'b0;
    end
    lat = 0; wr_cnt = 0; wr_cyc = 0; mis = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (bus.memWrite) begin
        wr_cnt++; wr_cyc = c; wr_data = bus.writeData; wr_adr = bus.memAdr;
      end
      if (bus.done) begin
        lat = c;
        ld  = bus.loadData;
`ifdef MISALIGN_TRAP_EN
        mis = bus.misaligned;
`endif
        bus.req = 1'b0;
      end
    end
  endtask

  initial begin
    int quiet;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h8899AABB;
    mem[32'h200 >> 2] = 32'h11223344;
    bus.req = 1'b0; bus.isStore = 1'b0; bus.memOp = 3'b000;
    bus.addr = 32'h0; bus.storeData = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_memWrite", {31'b0, bus.memWrite}, 32'h0);
    chk("rst_loadData", bus.loadData, 32'h0);
    chk("rst_writeData", bus.writeData, 32'h0);
    chk("rst_memAdr", bus.memAdr, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_misaligned", {31'b0, bus.misaligned}, 32'h0);
`endif
    rst = 1'b1;

    run_op(1'b0, LB, 32'h101, 32'h0, 1'b0);
    chk("lb_data", ld, 32'hFFFFFFAA);
    chk("lb_lat", lat, 2);
    chk("lb_nowrite", wr_cnt, 0);

    run_op(1'b0, LHU, 32'h102, 32'h0, 1'b0);
    chk("lhu_data", ld, 32'h00008899);
    run_op(1'b0, LH, 32'h102, 32'h0, 1'b0);
    chk("lh_data", ld, 32'hFFFF8899);
    run_op(1'b0, LBU, 32'h100, 32'h0, 1'b0);
    chk("lbu_data", ld, 32'h000000BB);

    run_op(1'b0, LW, 32'h100, 32'h0, 1'b1);
    chk("lw_hold_data", ld, 32'h8899AABB);
    chk("lw_hold_lat", lat, 2);
    chk("lw_hold_nowrite", wr_cnt, 0);
    @(negedge clk);
    chk("lw_hold_idle", {31'b0, bus.busy}, 32'h0);
    chk("lw_hold_mem", memw(32'h100), 32'h8899AABB);

    run_op(1'b1, SB, 32'h203, 32'h000000A5, 1'b0);
    chk("sb_wcnt", wr_cnt, 1);
    chk("sb_wdata", wr_data, 32'hA5223344);
    chk("sb_wadr", wr_adr, 32'h200);
    chk("sb_lat", lat, 3);
    @(negedge clk);
    chk("sb_mem", memw(32'h200), 32'hA5223344);

    run_op(1'b1, SW, 32'h300, 32'hDEADBEEF, 1'b0);
    chk("sw_wcnt", wr_cnt, 1);
    chk("sw_wcyc", wr_cyc, 1);
    chk("sw_wdata", wr_data, 32'hDEADBEEF);
    chk("sw_lat", lat, 2);
    run_op(1'b0, LW, 32'h300, 32'h0, 1'b0);
    chk("sw_reread", ld, 32'hDEADBEEF);

    run_op(1'b1, SH, 32'h302, 32'hCAFE5566, 1'b0);
    chk("sh_wdata", wr_data, 32'h5566BEEF);
    chk("sh_lat", lat, 3);
    run_op(1'b0, LHU, 32'h300, 32'h0, 1'b0);
    chk("sh_lo_kept", ld, 32'h0000BEEF);

    run_op(1'b0, 3'b111, 32'h200, 32'h0, 1'b0);
    chk("op111_as_w", ld, 32'hA5223344);
    run_op(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
    chk("op011_as_w", ld, 32'h8899AABB);

    @(negedge clk);
    bus.req = 1'b1; bus.isStore = 1'b1; bus.memOp = SH; bus.addr = 32'h202; bus.storeData = 32'h7777;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    chk("abort_busy_read", {31'b0, bus.busy}, 32'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_done", {31'b0, bus.done}, 32'h0);
    chk("abort_memAdr", bus.memAdr, 32'h0);
    chk("abort_loadData", bus.loadData, 32'h0);
    rst = 1'b1;
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.memWrite || bus.done) quiet++;
    end
    chk("abort_quiet", quiet, 0);
    chk("abort_mem", memw(32'h200), 32'hA5223344);

    run_op(1'b0, LW, 32'h102, 32'h0, 1'b0);
    chk("mis_nowrite", wr_cnt, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_flag", {31'b0, mis}, 32'h1);
    chk("mis_lat", lat, 1);
    chk("mis_loadData_held", ld, 32'h0);
`else
    chk("mis_flag", {31'b0, mis}, 32'h0);
    chk("mis_trunc_lat", lat, 2);
    chk("mis_trunc_data", ld, 32'h8899AABB);
`endif
    run_op(1'b0, LH, 32'h101, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_lh_flag", {31'b0, mis}, 32'h1);
    chk("mis_lh_held", ld, 32'h0);
`else
    chk("mis_lh_trunc", ld, 32'hFFFFAABB);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning data/address width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port req, input, 1, CPU access request, sampled only in IDLE.
REQ-005 The block SHALL have port isStore, input, 1, 1=store and 0=load, sampled with req.
REQ-006 The block SHALL have port memOp, input, 3, RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu), sampled with req.
REQ-007 The block SHALL have port addr, input, N, byte address, sampled with req.
REQ-008 The block SHALL have port storeData, input, N, store operand (low bits used for b/h), sampled with req.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port loadData, output, N, aligned and extended load result, valid while done=1 and held afterwards.
REQ-012 The block SHALL have port memAdr, output, N, word address to data memory, always {addrLatched[31:2],2'b00}.
REQ-013 The block SHALL have port writeData, output, N, word written to data memory.
REQ-014 The block SHALL have port memWrite, output, 1, word write strobe to data memory.
REQ-015 The block SHALL have port readData, input, N, combinational little-endian word from data memory (byte at memAdr in [7:0]).

Function
REQ-016 The FSM SHALL use states IDLE, READ, WRITE, DONE.
REQ-017 IDLE with req=1 SHALL latch isStore, memOp, addr and storeData, then go to READ for a load or sub-word store, or to WRITE for an sw.
REQ-018 READ SHALL register readData into an internal word buffer and go to DONE for a load or WRITE for a store; memWrite=0.
REQ-019 WRITE SHALL drive memWrite=1 for exactly one cycle with writeData = storeData (sw) or the buffer with the addressed byte/halfword lane replaced, then go to DONE.
REQ-020 DONE SHALL assert done=1 for one cycle and return to IDLE; req may be accepted on the next IDLE cycle.
REQ-021 Latency from req-sampling edge to the done cycle SHALL be: load 2 cycles, sw 2 cycles, sb/sh 3 cycles.
REQ-022 Lane selection SHALL be: byte lane addr[1:0]; halfword lane addr[1] (low or high 16 bits).
REQ-023 lb and lh SHALL sign-extend to N bits; lbu and lhu SHALL zero-extend; lw SHALL pass the word unchanged.
REQ-024 req asserted while busy=1 SHALL be ignored, with no queuing.
REQ-025 memOp codes 011, 110 and 111 SHALL be treated as w.
REQ-026 memWrite SHALL never be high outside WRITE.

Reset
REQ-027 rst=0 at a clock edge SHALL force IDLE, busy=0, done=0, memWrite=0, loadData=0, writeData=0 and clear the latched address, so memAdr=0.
REQ-028 Reset mid-operation (READ or WRITE) SHALL abort the operation; no memWrite pulse and no done SHALL follow.

Configuration
REQ-029 With MISALIGN_TRAP_EN defined, the block SHALL add output misaligned (1 bit, reset 0) and an ERR state.
REQ-030 With MISALIGN_TRAP_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL go IDLE->ERR->IDLE, with no memory access, misaligned=1 and done=1 for the one ERR cycle, and loadData unchanged.
REQ-031 Without MISALIGN_TRAP_EN, there SHALL be no misaligned port, and misaligned offsets SHALL be silently truncated: halfword uses addr[1], word ignores addr[1:0].

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (localparams) and the memOp funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-033 Lane merge (store) and lane extract/extend (load) SHALL be a combinational sub-module lsu_lane_align, instantiated once.

Verification
REQ-034 Scenario: memory word at 0x100 = 0x8899AABB; lb at addr 0x101 -> loadData=0xFFFFFFAA, done 2 cycles after req.
REQ-035 Scenario: same word; lhu at 0x102 -> loadData=0x00008899; lh at 0x102 -> 0xFFFF8899.
REQ-036 Scenario: word at 0x200 = 0x11223344; sb 0xA5 at 0x203 -> one memWrite pulse with writeData=0xA5223344 and memAdr=0x200; done 3 cycles after req.
REQ-037 Scenario: sw 0xDEADBEEF at 0x300 -> memWrite on the first cycle after acceptance; done 2 cycles after req; re-read gives 0xDEADBEEF.
REQ-038 Scenario: rst=0 during the READ of an sh -> no memWrite, no done, busy=0 on the next cycle, memory unchanged.
REQ-039 Scenario: with MISALIGN_TRAP_EN defined, lw at 0x102 -> misaligned=1 and done=1 one cycle after req, memWrite=0; without the macro, the same access returns the word at 0x100.
